// File: rtl/piece_sequencer_pkg.sv
// Shared types for the piece sequencer: move-bit indices, state encoding
// and the lateral/rotate arbitration helper.
package piece_sequencer_pkg;

    localparam int unsigned MV_W    = 5;
    localparam int unsigned SPEED_W = 6;
    localparam int unsigned STATE_W = 3;

    localparam int unsigned MV_LEFT  = 4;
    localparam int unsigned MV_RIGHT = 3;
    localparam int unsigned MV_ROTR  = 2;
    localparam int unsigned MV_ROTL  = 1;
    localparam int unsigned MV_DOWN  = 0;

    localparam logic [MV_W-1:0] MV_DOWN_OH = MV_W'(1 << MV_DOWN);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SPAWN     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_FALL      = 3'd3,
        ST_LOCK      = 3'd4,
        ST_HDROP     = 3'd5,
        ST_GAME_OVER = 3'd6
    } seq_state_e;

    // One-hot winner among lateral/rotate requests; req carries bits [4:1]
    // of the move vector. Priority rotR > rotL > L > R.
    function automatic logic [MV_W-1:0] pick_lateral(input logic [MV_W-2:0] req);
        logic [MV_W-1:0] grant;
        grant = '0;
        if (req[MV_ROTR-1])       grant[MV_ROTR]  = 1'b1;
        else if (req[MV_ROTL-1])  grant[MV_ROTL]  = 1'b1;
        else if (req[MV_LEFT-1])  grant[MV_LEFT]  = 1'b1;
        else if (req[MV_RIGHT-1]) grant[MV_RIGHT] = 1'b1;
        return grant;
    endfunction

endpackage

// File: rtl/piece_sequencer_if.sv
// Request/command bundle between the input/board side and the sequencer.
interface piece_sequencer_if;
    import piece_sequencer_pkg::*;

    logic               start;
    logic               frame_clk_rising_edge;
    logic [SPEED_W-1:0] level_speed;
    logic [MV_W-1:0]    req_move;
    logic               hard_drop;
    logic               soft_drop;
    logic [MV_W-1:0]    can_move;
    logic               BOARD_BUSY;
    logic [MV_W-1:0]    move_cmd;
    logic               get_new_block;
    logic               game_over;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        output start, frame_clk_rising_edge, level_speed, req_move,
               hard_drop, soft_drop, can_move, BOARD_BUSY,
        input  move_cmd, get_new_block, game_over, state_dbg
    );

    modport slave (
        input  start, frame_clk_rising_edge, level_speed, req_move,
               hard_drop, soft_drop, can_move, BOARD_BUSY,
        output move_cmd, get_new_block, game_over, state_dbg
    );

endinterface

// File: rtl/piece_sequencer_frame_divider.sv
// Frame-tick counter that flags the tick on which count+1 reaches limit,
// then wraps to zero. Used for both gravity and lock timing.
module piece_sequencer_frame_divider #(
    parameter int unsigned W = 6
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         due_c
);

    logic [W-1:0] count;
    logic [W:0]   next_c;

    // One extra bit so a full-scale limit never wraps the compare.
    assign next_c = {1'b0, count} + (W+1)'(1);
    assign due_c  = tick && (next_c >= {1'b0, limit});

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= due_c ? '0 : next_c[W-1:0];
        end
    end

endmodule

// File: rtl/piece_sequencer.sv
// Game-flow controller: arbitrates player moves per frame, runs gravity and
// lock timing, pulses spawn/commit and flags game over.
module piece_sequencer
    import piece_sequencer_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = 30,
    parameter int unsigned SOFT_DIV    = 2,
    parameter int unsigned SETTLE_CYC  = 2
) (
    input logic             Clk,
    input logic             Reset_n,
    piece_sequencer_if.slave bus
);

    localparam int unsigned LOCK_W   = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned SETTLE_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    seq_state_e          state;
    logic [MV_W-1:0]     pend_mv;
    logic                pend_hd;
    logic                down_defer;
    logic                hd_phase;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [MV_W-1:0]     move_cmd_r;
    logic                get_new_block_r;
    logic                game_over_r;

    logic                edge_c;
    logic [MV_W-1:0]     eff_mv_c;
    logic                eff_hd_c;
    logic [MV_W-1:0]     lat_oh_c;
    logic                lat_go_c;
    logic [SPEED_W-1:0]  grav_limit_c;
    logic                grav_due_c;
    logic                lock_due_c;
    logic                settled_c;

    // A busy board freezes all frame-driven activity.
    assign edge_c   = bus.frame_clk_rising_edge && !bus.BOARD_BUSY;
    assign eff_mv_c = pend_mv | bus.req_move;
    assign eff_hd_c = pend_hd | bus.hard_drop;
    assign lat_oh_c = pick_lateral(eff_mv_c[MV_W-1:1]);
    assign lat_go_c = |(lat_oh_c & bus.can_move);

    assign grav_limit_c = bus.soft_drop             ? SPEED_W'(SOFT_DIV) :
                          (bus.level_speed == '0)   ? SPEED_W'(1)        :
                                                      bus.level_speed;

    assign settled_c = ((32'(settle_cnt) + 32'd1) >= SETTLE_CYC) && !bus.BOARD_BUSY;

    piece_sequencer_frame_divider #(.W(SPEED_W)) u_grav_div (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (state == ST_SPAWN),
        .tick    (edge_c && (state == ST_FALL)),
        .limit   (grav_limit_c),
        .due_c   (grav_due_c)
    );

    piece_sequencer_frame_divider #(.W(LOCK_W)) u_lock_div (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (state != ST_LOCK),
        .tick    (edge_c && (state == ST_LOCK)),
        .limit   (LOCK_W'(LOCK_FRAMES)),
        .due_c   (lock_due_c)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= ST_IDLE;
            pend_mv         <= '0;
            pend_hd         <= 1'b0;
            down_defer      <= 1'b0;
            hd_phase        <= 1'b0;
            settle_cnt      <= '0;
            move_cmd_r      <= '0;
            get_new_block_r <= 1'b0;
            game_over_r     <= 1'b0;
        end else begin
            move_cmd_r      <= '0;
            get_new_block_r <= 1'b0;

            // Requests only accumulate while a piece is live.
            if ((state == ST_FALL) || (state == ST_LOCK)) begin
                pend_mv <= eff_mv_c;
                pend_hd <= eff_hd_c;
                if (edge_c) begin
                    pend_mv <= '0;
                    pend_hd <= 1'b0;
                end
            end else begin
                pend_mv <= '0;
                pend_hd <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) state <= ST_SPAWN;
                end

                ST_SPAWN: begin
                    get_new_block_r <= 1'b1;
                    settle_cnt      <= '0;
                    down_defer      <= 1'b0;
                    state           <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (32'(settle_cnt) < SETTLE_CYC) settle_cnt <= settle_cnt + SETTLE_W'(1);
                    if (settled_c) begin
                        if (!bus.can_move[MV_DOWN]) begin
                            game_over_r <= 1'b1;
                            state       <= ST_GAME_OVER;
                        end else begin
                            state <= ST_FALL;
                        end
                    end
                end

                ST_FALL: begin
                    if (edge_c) begin
                        if (eff_hd_c) begin
                            hd_phase   <= 1'b0;
                            down_defer <= 1'b0;
                            state      <= ST_HDROP;
                        end else begin
                            if (lat_go_c) move_cmd_r <= lat_oh_c;
                            // A gravity step colliding with a lateral move slips one cycle.
                            if (grav_due_c || eff_mv_c[MV_DOWN]) begin
                                if (lat_go_c) begin
                                    down_defer <= 1'b1;
                                end else if (bus.can_move[MV_DOWN]) begin
                                    move_cmd_r <= MV_DOWN_OH;
                                end else begin
                                    state <= ST_LOCK;
                                end
                            end
                        end
                    end else if (down_defer && !bus.BOARD_BUSY) begin
                        down_defer <= 1'b0;
                        if (bus.can_move[MV_DOWN]) move_cmd_r <= MV_DOWN_OH;
                        else                       state      <= ST_LOCK;
                    end
                end

                ST_LOCK: begin
                    if (edge_c) begin
                        if (eff_hd_c) begin
                            state <= ST_SPAWN;
                        end else begin
                            if (lat_go_c) move_cmd_r <= lat_oh_c;
                            if (bus.can_move[MV_DOWN]) state <= ST_FALL;
                            else if (lock_due_c)       state <= ST_SPAWN;
                        end
                    end
                end

                ST_HDROP: begin
                    // Even phase checks the floor, odd phase lets can_move catch up.
                    hd_phase <= ~hd_phase;
                    if (!hd_phase) begin
                        if (bus.can_move[MV_DOWN]) move_cmd_r <= MV_DOWN_OH;
                        else                       state      <= ST_SPAWN;
                    end
                end

                ST_GAME_OVER: begin
                    if (bus.start) begin
                        game_over_r <= 1'b0;
                        state       <= ST_SPAWN;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.move_cmd      = move_cmd_r;
    assign bus.get_new_block = get_new_block_r;
    assign bus.game_over     = game_over_r;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer: spawn/settle, gravity, arbitration,
// lock timing, hard drop, game over and reset mid-drop.
module tb_piece_sequencer;
    import piece_sequencer_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   gnb_total = 0;

    piece_sequencer_if bus();

    piece_sequencer #(
        .LOCK_FRAMES (30),
        .SOFT_DIV    (2),
        .SETTLE_CYC  (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (bus.get_new_block === 1'b1) gnb_total++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame edge carrying req; mc = move_cmd the cycle after, mc2 = one cycle later.
    task automatic frame(input logic [4:0] req, output logic [4:0] mc, output logic [4:0] mc2);
        @(negedge Clk);
        bus.frame_clk_rising_edge = 1'b1;
        bus.req_move              = req;
        @(negedge Clk);
        bus.frame_clk_rising_edge = 1'b0;
        bus.req_move              = '0;
        mc = bus.move_cmd;
        @(negedge Clk);
        mc2 = bus.move_cmd;
        @(negedge Clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int k;
        k = 0;
        while ((k < limit) && (bus.state_dbg !== s)) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, bus.state_dbg, s);
    endtask

    initial begin
        logic [4:0] mc;
        logic [4:0] mc2;
        int cnt;
        int last;
        int gaps_bad;
        int pulses;
        int rows;
        int gb;
        logic seen;

        Reset_n                   = 1'b0;
        bus.start                 = 1'b0;
        bus.frame_clk_rising_edge = 1'b0;
        bus.level_speed           = 6'd3;
        bus.req_move              = '0;
        bus.hard_drop             = 1'b0;
        bus.soft_drop             = 1'b0;
        bus.can_move              = 5'b11111;
        bus.BOARD_BUSY            = 1'b0;

        #12;
        chk("rst_state", bus.state_dbg, ST_IDLE);
        chk("rst_move_cmd", bus.move_cmd, 5'b0);
        chk("rst_gnb", bus.get_new_block, 1'b0);
        chk("rst_game_over", bus.game_over, 1'b0);

        // Start: one spawn pulse within two cycles, then FALL after settling
        @(negedge Clk); Reset_n = 1'b1;
        @(negedge Clk); bus.start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            if (bus.get_new_block === 1'b1) cnt++;
        end
        bus.start = 1'b0;
        chk("t1_spawn_pulses", cnt, 1);
        wait_state(ST_FALL, 8, "t1_reach_fall");

        // Gravity at level_speed=3
        for (int f = 1; f <= 6; f++) begin
            frame(5'b0, mc, mc2);
            chk($sformatf("t2_grav_f%0d", f), mc, ((f % 3) == 0) ? 5'b00001 : 5'b00000);
        end

        // rotR beats L in the same frame; L is dropped, not carried over
        frame(5'b10100, mc, mc2);
        chk("t3_rotr_wins", mc, 5'b00100);
        chk("t3_no_second_cmd", mc2, 5'b00000);
        frame(5'b0, mc, mc2);
        chk("t3_left_dropped", mc, 5'b00000);
        frame(5'b0, mc, mc2);
        chk("t3_grav_after", mc, 5'b00001);

        // Lateral and gravity on the same edge: down slips one cycle
        frame(5'b0, mc, mc2);
        frame(5'b0, mc, mc2);
        frame(5'b01000, mc, mc2);
        chk("t3_defer_lateral", mc, 5'b01000);
        chk("t3_defer_down", mc2, 5'b00001);

        // Grounded: enter LOCK, slide off at lock frame 10
        bus.can_move = 5'b11110;
        frame(5'b0, mc, mc2);
        frame(5'b0, mc, mc2);
        frame(5'b0, mc, mc2);
        chk("t4_no_down_when_blocked", mc, 5'b00000);
        chk("t4_enter_lock", bus.state_dbg, ST_LOCK);
        gb = gnb_total;
        for (int f = 1; f <= 9; f++) frame(5'b0, mc, mc2);
        bus.can_move = 5'b11111;
        frame(5'b0, mc, mc2);
        chk("t4_slide_to_fall", bus.state_dbg, ST_FALL);
        chk("t4_slide_no_commit", gnb_total, gb);

        // Grounded again: commit exactly on lock frame 30
        bus.can_move = 5'b11110;
        frame(5'b0, mc, mc2);
        frame(5'b0, mc, mc2);
        frame(5'b0, mc, mc2);
        chk("t4_enter_lock2", bus.state_dbg, ST_LOCK);
        gb = gnb_total;
        for (int f = 1; f <= 29; f++) frame(5'b0, mc, mc2);
        chk("t4_no_early_commit", gnb_total, gb);
        chk("t4_still_lock_f29", bus.state_dbg, ST_LOCK);
        frame(5'b0, mc, mc2);
        bus.can_move = 5'b11111;
        chk("t4_commit_f30", gnb_total, gb + 1);
        wait_state(ST_FALL, 8, "t4_respawn_fall");

        // Hard drop onto a floor 5 rows down
        rows = 5;
        @(negedge Clk);
        bus.hard_drop             = 1'b1;
        bus.frame_clk_rising_edge = 1'b1;
        @(negedge Clk);
        bus.hard_drop             = 1'b0;
        bus.frame_clk_rising_edge = 1'b0;
        pulses = 0; last = -1; gaps_bad = 0; seen = 1'b0; cnt = 0;
        while (!seen && (cnt < 60)) begin
            if (bus.move_cmd === 5'b00001) begin
                pulses++;
                if ((last >= 0) && ((cnt - last) != 2)) gaps_bad++;
                last = cnt;
                rows--;
                bus.can_move[0] = (rows > 0);
            end else if (bus.move_cmd !== 5'b00000) begin
                gaps_bad++;
            end
            if (bus.get_new_block === 1'b1) seen = 1'b1;
            @(negedge Clk);
            cnt++;
        end
        chk("t5_down_pulses", pulses, 5);
        chk("t5_pulse_spacing", gaps_bad, 0);
        chk("t5_commit_seen", seen, 1'b1);

        // Spawn into a blocked board: game over, commands suppressed
        wait_state(ST_GAME_OVER, 8, "t6_game_over_state");
        chk("t6_game_over_flag", bus.game_over, 1'b1);
        frame(5'b10000, mc, mc2);
        chk("t6_no_cmd", mc | mc2, 5'b00000);
        chk("t6_hold_state", bus.state_dbg, ST_GAME_OVER);
        bus.can_move = 5'b11111;
        @(negedge Clk); bus.start = 1'b1;
        @(negedge Clk); bus.start = 1'b0;
        chk("t6_restart_spawn", bus.state_dbg, ST_SPAWN);
        chk("t6_game_over_clear", bus.game_over, 1'b0);
        gb = gnb_total;
        wait_state(ST_FALL, 8, "t6_restart_fall");
        chk("t6_restart_gnb", gnb_total, gb + 1);

        // level_speed=0 behaves as 1: a down step every frame
        bus.level_speed = 6'd0;
        frame(5'b0, mc, mc2);
        chk("t7_speed0_f1", mc, 5'b00001);
        frame(5'b0, mc, mc2);
        chk("t7_speed0_f2", mc, 5'b00001);

        // Reset mid hard drop leaves nothing behind
        @(negedge Clk);
        bus.hard_drop             = 1'b1;
        bus.frame_clk_rising_edge = 1'b1;
        @(negedge Clk);
        bus.hard_drop             = 1'b0;
        bus.frame_clk_rising_edge = 1'b0;
        @(negedge Clk);
        chk("t8_in_hdrop", bus.state_dbg, ST_HDROP);
        gb = gnb_total;
        Reset_n = 1'b0;
        #1;
        chk("t8_rst_state", bus.state_dbg, ST_IDLE);
        chk("t8_rst_move_cmd", bus.move_cmd, 5'b00000);
        @(negedge Clk);
        @(negedge Clk); Reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if ((bus.move_cmd !== 5'b00000) || (bus.state_dbg !== ST_IDLE)) cnt++;
        end
        chk("t8_quiet_after_reset", cnt, 0);
        chk("t8_no_residual_gnb", gnb_total, gb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
